// File: rtl/system_led_driver_if.sv
// Avalon-MM slave bus for the LED driver register file.
// The master modport is the bus initiator; the slave modport is the register block.
interface system_led_driver_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/system_led_driver.sv
// LED lane driver: PWM dimming, frame-based blink and polarity inversion of a PIO pattern,
// controlled through a four-word Avalon-MM register file.
module system_led_driver #(
  parameter int WIDTH  = 10,
  parameter int BDIV_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [WIDTH-1:0]    led_in,
  system_led_driver_if.slave  bus,
  output logic [WIDTH-1:0]    led_out
);

  logic              enable;
  logic              blink_en;
  logic              invert;
  logic [7:0]        duty;
  logic [BDIV_W-1:0] bdiv;
  logic [7:0]        pwm_cnt;
  logic [BDIV_W-1:0] blink_cnt;
  logic              blink_phase;
  logic [WIDTH-1:0]  led_p1;

  logic              wr;
  logic              frame_tick;
  logic              pwm_on;
  logic [WIDTH-1:0]  gated_p0;
  logic              unused_wdata;

  assign wr           = bus.chipselect && !bus.write_n;
  assign frame_tick   = enable && (pwm_cnt == 8'hFF);
  assign pwm_on       = (duty == 8'hFF) ? 1'b1 : (pwm_cnt < duty);
  assign unused_wdata = ^bus.writedata[31:BDIV_W];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable   <= 1'b1;
      blink_en <= 1'b0;
      invert   <= 1'b0;
      duty     <= 8'hFF;
      bdiv     <= BDIV_W'(16'h00C3);
    end else if (wr) begin
      case (bus.address)
        2'd0: begin
          enable   <= bus.writedata[0];
          blink_en <= bus.writedata[1];
          invert   <= bus.writedata[2];
        end
        2'd1:    duty <= bus.writedata[7:0];
        2'd2:    bdiv <= bus.writedata[BDIV_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= 8'd0;
    end else if (!enable) begin
      pwm_cnt <= 8'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // A BDIV write restarts the half-period count and outranks a coincident frame tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (!blink_en) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (wr && (bus.address == 2'd2)) begin
      blink_cnt   <= '0;
    end else if (frame_tick) begin
      if (blink_cnt == bdiv) begin
        blink_cnt   <= '0;
        blink_phase <= !blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BDIV_W'(1);
      end
    end
  end

  // Stage p0 -> p1: gate the pattern, apply polarity, register to the pins.
  assign gated_p0 = led_in & {WIDTH{enable && pwm_on && blink_phase}};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      led_p1 <= '0;
    end else begin
      led_p1 <= gated_p0 ^ {WIDTH{invert}};
    end
  end

  assign led_out = led_p1;

  always_comb begin
    bus.readdata = 32'd0;
    case (bus.address)
      2'd0: bus.readdata[2:0]        = {invert, blink_en, enable};
      2'd1: bus.readdata[7:0]        = duty;
      2'd2: bus.readdata[BDIV_W-1:0] = bdiv;
      2'd3: bus.readdata[8:0]        = {blink_phase, pwm_cnt};
      default: ;
    endcase
  end

endmodule

// File: tb/tb_system_led_driver.sv
// Directed bench for system_led_driver: reset state, PWM duty, blink timing,
// inversion, register masking, BDIV/frame-tick priority and mid-run reset.
module tb_system_led_driver;
  localparam int WIDTH = 10;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] led_in;
  logic [WIDTH-1:0] led_out;
  int               n_cmp;
  int               n_bad;

  system_led_driver_if bif ();

  system_led_driver #(.WIDTH(WIDTH), .BDIV_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .led_in  (led_in),
    .bus     (bif.slave),
    .led_out (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bif.address    = a;
    bif.writedata  = d;
    bif.chipselect = 1'b1;
    bif.write_n    = 1'b0;
    @(negedge clk);
    bif.chipselect = 1'b0;
    bif.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bif.address = a;
    #1;
    d = bif.readdata;
  endtask

  initial begin
    logic [31:0]      rd;
    logic [WIDTH-1:0] prev;
    logic             ph;
    int               n, on_cnt, off_cnt, bad;

    n_cmp = 0;
    n_bad = 0;
    reset_n        = 1'b0;
    led_in         = 10'h111;
    bif.address    = 2'd0;
    bif.chipselect = 1'b0;
    bif.write_n    = 1'b1;
    bif.writedata  = 32'd0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_led_out", 32'(led_out), 32'h0);
    bus_read(2'd0, rd); chk("rst_ctrl", rd, 32'h1);
    bus_read(2'd1, rd); chk("rst_duty", rd, 32'hFF);
    bus_read(2'd2, rd); chk("rst_bdiv", rd, 32'hC3);
    bus_read(2'd3, rd); chk("rst_status", rd, 32'h100);

    // Pass-through at full brightness one clock after release
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("pass_first", 32'(led_out), 32'h111);
    bus_read(2'd3, rd); chk("pass_status", rd, 32'h101);
    bad = 0;
    repeat (600) begin
      @(negedge clk);
      if (led_out !== 10'h111) bad++;
    end
    chk("pass_stable_bad", 32'(bad), 32'd0);
    bus_read(2'd1, rd); chk("pass_duty", rd, 32'hFF);

    // DUTY=64: on for 64 of every 256 clocks; upper write bits masked
    led_in = 10'h3FF;
    bus_write(2'd1, 32'h1234_5640);
    bus_read(2'd1, rd); chk("duty_readback", rd, 32'h40);
    @(negedge clk);
    on_cnt = 0;
    off_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (led_out === 10'h3FF) on_cnt++;
      else if (led_out === 10'h000) off_cnt++;
    end
    chk("duty64_on", 32'(on_cnt), 32'd64);
    chk("duty64_off", 32'(off_cnt), 32'd192);

    bus_write(2'd1, 32'h0);
    @(negedge clk);
    bad = 0;
    repeat (512) begin
      @(negedge clk);
      if (led_out !== 10'h000) bad++;
    end
    chk("duty0_lit", 32'(bad), 32'd0);

    // enable=0, invert=1: output fully inverted regardless of led_in
    bus_write(2'd0, 32'hFFFF_FFFC);
    led_in = 10'h155;
    repeat (3) @(negedge clk);
    #1;
    chk("inv_led_155", 32'(led_out), 32'h3FF);
    bus_read(2'd0, rd); chk("inv_ctrl", rd, 32'h4);
    bus_read(2'd3, rd); chk("inv_status", rd, 32'h100);
    led_in = 10'h000;
    @(negedge clk);
    #1;
    chk("inv_led_000", 32'(led_out), 32'h3FF);
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_read(2'd3, rd); chk("status_ro", rd, 32'h100);
    // Strobes without a full write qualifier must not update DUTY
    @(negedge clk);
    bif.address = 2'd1; bif.writedata = 32'h77;
    bif.chipselect = 1'b1; bif.write_n = 1'b1;
    @(negedge clk);
    bif.chipselect = 1'b0; bif.write_n = 1'b0;
    @(negedge clk);
    bif.write_n = 1'b1;
    bus_read(2'd1, rd); chk("no_write_duty", rd, 32'h0);

    // Blink: BDIV=1 -> 2 frames per half-period = 512 clocks
    bus_write(2'd1, 32'hFF);
    bus_write(2'd2, 32'h1);
    bus_read(2'd2, rd); chk("bdiv_readback", rd, 32'h1);
    led_in = 10'h3FF;
    bus_write(2'd0, 32'h3);
    @(negedge clk);
    prev = led_out;
    n = 0;
    while (led_out === prev && n < 1200) begin
      @(negedge clk);
      n++;
    end
    for (int r = 0; r < 2; r++) begin
      prev = led_out;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (led_out === prev && n < 1200);
      chk("blink_run", 32'(n), 32'd512);
      chk("blink_swing", 32'(prev ^ led_out), 32'h3FF);
    end

    // BDIV write coincident with frame tick: clear wins, no toggle
    bus_write(2'd2, 32'h0);
    bif.address = 2'd3;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      rd = bif.readdata;
      n++;
    end while (rd[7:0] !== 8'hFF && n < 300);
    chk("tick_found", 32'(rd[7:0]), 32'hFF);
    ph = rd[8];
    bif.address = 2'd2; bif.writedata = 32'h0;
    bif.chipselect = 1'b1; bif.write_n = 1'b0;
    @(negedge clk);
    bif.chipselect = 1'b0; bif.write_n = 1'b1;
    bus_read(2'd3, rd); chk("coinc_no_toggle", rd, {23'd0, ph, 8'h00});
    n = 0;
    do begin
      @(negedge clk);
      #1;
      rd = bif.readdata;
      n++;
    end while (rd[7:0] !== 8'hFF && n < 300);
    @(negedge clk);
    #1;
    chk("next_tick_toggle", bif.readdata, {23'd0, ~ph, 8'h00});

    // Reset pulse mid-blink
    bus_write(2'd0, 32'h1);
    bus_write(2'd2, 32'h5);
    bus_write(2'd0, 32'h3);
    repeat (100) @(negedge clk);
    #1;
    chk("preblink_led", 32'(led_out), 32'h3FF);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_led", 32'(led_out), 32'h0);
    bus_read(2'd0, rd); chk("midrst_ctrl", rd, 32'h1);
    bus_read(2'd1, rd); chk("midrst_duty", rd, 32'hFF);
    bus_read(2'd2, rd); chk("midrst_bdiv", rd, 32'hC3);
    bus_read(2'd3, rd); chk("midrst_status", rd, 32'h100);
    @(negedge clk);
    reset_n = 1'b1;
    led_in = 10'h0A5;
    @(negedge clk);
    #1;
    chk("rerelease_led", 32'(led_out), 32'h0A5);
    bus_read(2'd3, rd); chk("rerelease_status", rd, 32'h101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
